// File: rtl/hdmi_video_pkg.sv
// Shared 720p video timing constants, lock FSM state type and pixel layout
// for the HDMI receive path.
package hdmi_video_pkg;

  localparam int H_FRONT_PORCH  = 110;
  localparam int H_SYNC         = 40;
  localparam int H_BACK_PORCH   = 220;
  localparam int H_ACTIVE_720P  = 1280;
  localparam int H_TOTAL        = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH + H_ACTIVE_720P;
  localparam int V_FRONT_PORCH  = 5;
  localparam int V_SYNC         = 5;
  localparam int V_BACK_PORCH   = 20;
  localparam int V_ACTIVE_720P  = 720;
  localparam int V_TOTAL        = V_FRONT_PORCH + V_SYNC + V_BACK_PORCH + V_ACTIVE_720P;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  // Four equal vertical colour bands across the active width.
  function automatic pixel_t band_pixel(input int unsigned idx, input int unsigned h_active);
    pixel_t p;
    if (idx < h_active / 4)          p = '{b: 8'h00, g: 8'h00, r: 8'hFF};
    else if (idx < h_active / 2)     p = '{b: 8'h00, g: 8'hFF, r: 8'h00};
    else if (idx < 3 * h_active / 4) p = '{b: 8'hFF, g: 8'h00, r: 8'h00};
    else                             p = '{b: 8'hFF, g: 8'hFF, r: 8'hFF};
    return p;
  endfunction

endpackage

// File: rtl/hdmi_rx_lock_fsm.sv
// Timing lock tracker: checks line length at each de fall and line count at
// each frame start, and reports lock state plus a one-cycle error pulse.
module hdmi_rx_lock_fsm
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int HW       = $clog2(H_ACTIVE + 2) + 1,
  parameter int VW       = $clog2(V_ACTIVE + 2) + 1
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  input  logic          frame_start_i,
  input  logic          de_fall_i,
  input  logic [HW-1:0] line_len_i,
  input  logic [VW-1:0] line_cnt_i,
  output logic          locked_o,
  output logic          frame_err_o
);

  lock_state_t state_q, state_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        line_bad, frame_bad;

  always_comb begin
    line_bad  = de_fall_i && (line_len_i != HW'(H_ACTIVE));
    // line_cnt_i already includes a de fall landing on the frame-start cycle
    frame_bad = frame_start_i && (line_cnt_i != VW'(V_ACTIVE));
    state_d   = state_q;
    err_d     = 1'b0;
    unique case (state_q)
      UNLOCKED: if (frame_start_i) state_d = CHECK;
      CHECK: begin
        if (line_bad || frame_bad) state_d = UNLOCKED;
        else if (frame_start_i)    state_d = LOCKED;
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_d = UNLOCKED;
          err_d   = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= UNLOCKED;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign locked_o    = locked_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/hdmi_rx_stream.sv
// HDMI pixel capture to a line-packetised stream, gated by timing lock.
// Define HDMI_RX_TESTPAT_EN to replace captured data with four colour bands.
module hdmi_rx_stream
  import hdmi_video_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P
) (
  input  logic                  pixel_clk,
  input  logic                  reset_n,
  input  logic                  de_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic [7:0]            data_r_i,
  input  logic [7:0]            data_g_i,
  input  logic [7:0]            data_b_i,
  output logic                  aso_src_valid_o,
  output logic [DATA_WIDTH-1:0] aso_src_data_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic                  locked_o,
  output logic                  frame_err_o
);

  localparam int HW = $clog2(H_ACTIVE + 2) + 1;
  localparam int VW = $clog2(V_ACTIVE + 2) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [VW-1:0] V_MAX  = '1;

  // stage 1: raw capture plus previous-cycle copies for edge detection
  logic   de_s1_q, de_s1_d, de_p_q, de_p_d;
  logic   vs_s1_q, vs_s1_d, vs_p_q, vs_p_d;
  logic   hs_s1_q, hs_s1_d;
  pixel_t pix_s1_q, pix_s1_d;

  logic [HW-1:0] h_cnt_q, h_cnt_d, idx;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_seen;
  logic          line_en_q, line_en_d;
  logic          de_rise, de_fall, frame_start;
  pixel_t        pix_out;

  // stage 2: registered stream outputs
  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // hsync is kept for debug visibility only; line boundaries come from de
  logic hs_diag_unused;
  assign hs_diag_unused = hs_s1_q;

  always_comb begin
    de_s1_d  = de_i;
    de_p_d   = de_s1_q;
    vs_s1_d  = vsync_i;
    vs_p_d   = vs_s1_q;
    hs_s1_d  = hsync_i;
    pix_s1_d = '{b: data_b_i, g: data_g_i, r: data_r_i};

    de_rise     = de_s1_q & ~de_p_q;
    de_fall     = ~de_s1_q & de_p_q;
    frame_start = vs_p_q & ~vs_s1_q;

    idx     = de_rise ? '0 : h_cnt_q;
    h_cnt_d = h_cnt_q;
    if (de_s1_q) h_cnt_d = (idx == H_MAX) ? idx : idx + 1'b1;

    // de edge counted before the frame-start line-count check
    v_seen  = (de_fall && v_cnt_q != V_MAX) ? v_cnt_q + 1'b1 : v_cnt_q;
    v_cnt_d = frame_start ? '0 : v_seen;

    // lock state is sampled once per line, so a started line runs to its eop
    line_en_d = de_rise ? locked_o : line_en_q;

`ifdef HDMI_RX_TESTPAT_EN
    pix_out = band_pixel(32'(idx), H_ACTIVE);
`else
    pix_out = pix_s1_q;
`endif

    valid_d = de_s1_q & line_en_d & (idx < HW'(H_ACTIVE));
    sop_d   = valid_d & (idx == '0);
    // successor pixel is the one being sampled into stage 1 right now
    eop_d   = valid_d & (~de_i | (idx == H_LAST));
    data_d  = valid_d ? DATA_WIDTH'(pix_out) : '0;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s1_q   <= 1'b0;
      de_p_q    <= 1'b0;
      vs_s1_q   <= 1'b0;
      vs_p_q    <= 1'b0;
      hs_s1_q   <= 1'b0;
      pix_s1_q  <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      line_en_q <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      de_s1_q   <= de_s1_d;
      de_p_q    <= de_p_d;
      vs_s1_q   <= vs_s1_d;
      vs_p_q    <= vs_p_d;
      hs_s1_q   <= hs_s1_d;
      pix_s1_q  <= pix_s1_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      line_en_q <= line_en_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
    end
  end

  hdmi_rx_lock_fsm #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .HW       (HW),
    .VW       (VW)
  ) u_lock_fsm (
    .pixel_clk     (pixel_clk),
    .reset_n       (reset_n),
    .frame_start_i (frame_start),
    .de_fall_i     (de_fall),
    .line_len_i    (h_cnt_q),
    .line_cnt_i    (v_seen),
    .locked_o      (locked_o),
    .frame_err_o   (frame_err_o)
  );

  assign aso_src_valid_o         = valid_q;
  assign aso_src_data_o          = data_q;
  assign aso_src_startofpacket_o = sop_q;
  assign aso_src_endofpacket_o   = eop_q;

endmodule

// File: doc/hdmi_rx_stream.md
HDMI_RX_STREAM -- requirements
Module: hdmi_rx_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of the output stream data, packed {b,g,r}; the value SHALL be at least 24, and upper bits SHALL be zero.
REQ-002 Parameter H_ACTIVE, default 1280: expected active pixels per line.
REQ-003 Parameter V_ACTIVE, default 720: expected active lines per frame.
REQ-004 pixel_clk  in  1  pixel clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 de_i  in  1  data enable from the video source.
REQ-007 hsync_i  in  1  horizontal sync, active-low.
REQ-008 vsync_i  in  1  vertical sync, active-low.
REQ-009 data_r_i / data_g_i / data_b_i  in  8 each  pixel colour components.
REQ-010 aso_src_valid_o  out  1  stream pixel valid.
REQ-011 aso_src_data_o  out  DATA_WIDTH  stream pixel.
REQ-012 aso_src_startofpacket_o  out  1  first pixel of a line.
REQ-013 aso_src_endofpacket_o  out  1  last pixel of a line.
REQ-014 locked_o  out  1  input timing matches H_ACTIVE x V_ACTIVE.
REQ-015 frame_err_o  out  1  one-cycle pulse on any timing mismatch.

Function
REQ-016 All video inputs SHALL be registered once (stage 1), and all stream outputs SHALL be registered (stage 2): latency from de_i to aso_src_valid_o is fixed at 2 cycles.
REQ-017 Frame start SHALL be the vsync_i falling edge, detected from the stage-1 value and its previous value.
REQ-018 h_cnt SHALL clear on each de rising edge and increment for each stage-1 cycle with de high. v_cnt SHALL increment on each de falling edge and clear at frame start.
REQ-019 Packets are per line: sop SHALL be set on the pixel with h_cnt==0, and eop SHALL be set on the pixel whose successor has de low.
REQ-020 If h_cnt reaches H_ACTIVE, the remaining pixels SHALL NOT be emitted (valid low), and eop SHALL be forced on pixel H_ACTIVE-1.
REQ-021 For a one-pixel line, sop and eop SHALL both be set on the same beat.
REQ-022 The lock FSM SHALL have states UNLOCKED, CHECK and LOCKED; reset enters UNLOCKED.
REQ-023 UNLOCKED SHALL move to CHECK at frame start.
REQ-024 CHECK SHALL move to LOCKED at the next frame start if every line had exactly H_ACTIVE pixels and v_cnt == V_ACTIVE.
REQ-025 CHECK SHALL move to UNLOCKED on any mismatch.
REQ-026 LOCKED SHALL move to UNLOCKED on any mismatch and pulse frame_err_o for one cycle.
REQ-027 A line-length mismatch SHALL be evaluated at the de falling edge; a line-count mismatch SHALL be evaluated at frame start.
REQ-028 If frame start coincides with a de edge, the de edge SHALL be processed first and the line count checked afterwards.
REQ-029 locked_o SHALL equal (state == LOCKED), registered.
REQ-030 aso_src_valid_o SHALL be asserted only in LOCKED. A line already started when lock is lost SHALL complete through its eop; no later beats SHALL be emitted.
REQ-031 A line that begins while not LOCKED SHALL be suppressed entirely, so no eop is emitted without a matching sop.
REQ-032 hsync_i SHALL be used only for diagnostics; a de edge alone defines line boundaries.

Reset
REQ-033 When reset_n is low, all outputs, counters, pipeline registers and FSM state SHALL be 0 / UNLOCKED immediately, independent of pixel_clk.
REQ-034 A reset asserted mid-line SHALL discard the partial line, and no eop SHALL follow after release.
REQ-035 After release, the first frame start SHALL be required before CHECK is entered.

Configuration
REQ-036 With HDMI_RX_TESTPAT_EN defined, aso_src_data_o SHALL carry 4 equal vertical bands by h_cnt quarter: red {0,0,FF}, green {0,FF,0}, blue {FF,0,0}, white {FF,FF,FF}. All timing, sop/eop and lock behaviour SHALL be unchanged.
REQ-037 Without HDMI_RX_TESTPAT_EN, aso_src_data_o SHALL carry the captured {b,g,r}.

Structure
REQ-038 Package hdmi_video_pkg SHALL hold the 1280x720 timing constants (front porch, sync, back porch, active, totals), the lock_state_t enum, and the pixel_t {b,g,r} struct.
REQ-039 One sub-module, hdmi_rx_lock_fsm, SHALL contain the FSM and mismatch checks and drive locked_o and frame_err_o. The top level SHALL hold the capture pipeline and counters.

Verification
REQ-040 Clean 1280x720 input, 3 frames -> locked_o rises at the 2nd frame start. The 3rd frame yields 720 packets of 1280 beats, each with a single sop and eop, arriving 2 cycles after de.
REQ-041 While LOCKED, line 100 has 1279 pixels -> eop on beat 1279, frame_err_o pulses once at the de fall, locked_o drops, and no further beats are emitted.
REQ-042 While LOCKED, line 5 has 1285 pixels -> 1280 beats with eop on beat 1280, the 5 extra pixels are dropped, and frame_err_o pulses.
REQ-043 Frame with 719 lines -> at the next frame start, frame_err_o pulses and the FSM goes to UNLOCKED then CHECK.
REQ-044 reset_n pulsed low mid-line while LOCKED -> all outputs read 0 immediately, and after release no beats appear until re-lock.
REQ-045 HDMI_RX_TESTPAT_EN defined, locked -> beats 0-319 read 0x0000FF, 320-639 read 0x00FF00, 640-959 read 0xFF0000, and 960-1279 read 0xFFFFFF.
